// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor
//
// Purpose:
//   Reads back a seven-segment display bus, which may be another tile's
//   display pins looped back to this block. It synchronizes and
//   de-glitches the bus. Each stable pattern is decoded to a digit. The
//   block checks that successive digits advance by one, and it measures
//   the number of clock cycles between successive digit updates.
//
// Configuration:
//   SEVEN_SEGMENT_MONITOR_HEX_EN - when defined, the hex glyphs A,b,C,d,E,F
//   are legal and decode to 10..15. In that build the sequence check wraps
//   mod 16. When undefined, those glyphs are illegal patterns and the
//   sequence wraps mod 10.
//
// Parameters:
//   STABLE_CYCLES - consecutive identical synchronized samples needed (>=2)
//   PERIOD_W      - width of the period counter and period_out
//
// Ports:
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   seg_in      - segment bus {g,f,e,d,c,b,a}, active high, asynchronous
//   clr_err     - synchronous clear of the sticky error flags
//   digit_out   - last accepted digit
//   digit_valid - one-cycle pulse when digit_out updates
//   seq_err     - sticky: accepted digit was not previous digit + 1
//   pat_err     - sticky: a stable pattern was neither a glyph nor blank
//   period_out  - cycles between the last two digit_valid pulses
//   tracking    - high while following a digit sequence
module seven_segment_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic                clr_err,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  output logic                seq_err,
  output logic                pat_err,
  output logic [PERIOD_W-1:0] period_out,
  output logic                tracking
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES - 1);

`ifdef SEVEN_SEGMENT_MONITOR_HEX_EN
  localparam logic [3:0] LAST_DIGIT = 4'd15;
`else
  localparam logic [3:0] LAST_DIGIT = 4'd9;
`endif

  typedef enum logic {IDLE, TRACK} stateT;

  stateT               r_state;
  logic [6:0]          r_s1;
  logic [6:0]          r_s2;
  logic [6:0]          r_cand;
  logic [CNT_W-1:0]    r_stabCnt;
  logic                r_reported;
  logic [3:0]          r_digit;
  logic                r_valid;
  logic                r_seqErr;
  logic                r_patErr;
  logic [PERIOD_W-1:0] r_periodCnt;
  logic [PERIOD_W-1:0] r_period;

  logic                w_isLegal;
  logic                w_isBlank;
  logic [3:0]          w_digit;
  logic [3:0]          w_expected;
  logic                w_eval;
  logic                w_seqSet;
  logic                w_patSet;
  logic [PERIOD_W-1:0] w_periodNext;

  // Decode the current candidate pattern back to a digit.
  always_comb begin
    w_isLegal = 1'b1;
    w_digit   = 4'd0;
    case (r_cand)
      7'h3F: w_digit = 4'd0;
      7'h06: w_digit = 4'd1;
      7'h5B: w_digit = 4'd2;
      7'h4F: w_digit = 4'd3;
      7'h66: w_digit = 4'd4;
      7'h6D: w_digit = 4'd5;
      7'h7D: w_digit = 4'd6;
      7'h07: w_digit = 4'd7;
      7'h7F: w_digit = 4'd8;
      7'h6F: w_digit = 4'd9;
`ifdef SEVEN_SEGMENT_MONITOR_HEX_EN
      7'h77: w_digit = 4'd10;
      7'h7C: w_digit = 4'd11;
      7'h39: w_digit = 4'd12;
      7'h5E: w_digit = 4'd13;
      7'h79: w_digit = 4'd14;
      7'h71: w_digit = 4'd15;
`endif
      default: w_isLegal = 1'b0;
    endcase
  end

  assign w_isBlank  = (r_cand == 7'h00);
  assign w_expected = (r_digit == LAST_DIGIT) ? 4'd0 : r_digit + 4'd1;

  // A candidate is evaluated once, on the cycle it has been seen for
  // STABLE_CYCLES consecutive samples and has not yet been reported.
  assign w_eval = (r_s2 == r_cand) && (r_stabCnt == STAB_MAX) && !r_reported;

  assign w_seqSet = w_eval && w_isLegal && (r_state == TRACK) &&
                    (w_digit != w_expected);
  assign w_patSet = w_eval && !w_isLegal && !w_isBlank;

  // The counter value one cycle later is the number of cycles since the
  // last accepted digit, so that value is captured as the period.
  assign w_periodNext = (&r_periodCnt) ? r_periodCnt : r_periodCnt + 1'b1;

  // Synchronizer, stability filter, tracking FSM and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s1        <= '0;
      r_s2        <= '0;
      r_cand      <= '0;
      r_stabCnt   <= '0;
      r_reported  <= 1'b0;
      r_digit     <= '0;
      r_valid     <= 1'b0;
      r_seqErr    <= 1'b0;
      r_patErr    <= 1'b0;
      r_periodCnt <= '0;
      r_period    <= '0;
    end else begin
      r_s1        <= seg_in;
      r_s2        <= r_s1;
      r_valid     <= 1'b0;
      r_periodCnt <= w_periodNext;

      if (r_s2 != r_cand) begin
        r_cand     <= r_s2;
        r_stabCnt  <= '0;
        r_reported <= 1'b0;
      end else if (r_stabCnt != STAB_MAX) begin
        r_stabCnt <= r_stabCnt + 1'b1;
      end else if (!r_reported) begin
        r_reported <= 1'b1;
        if (w_isLegal) begin
          r_digit     <= w_digit;
          r_valid     <= 1'b1;
          r_periodCnt <= '0;
          r_state     <= TRACK;
          if (r_state == TRACK) begin
            r_period <= w_periodNext;
          end
        end else begin
          r_state <= IDLE;
        end
      end

      // A new error event takes priority over a simultaneous clear.
      r_seqErr <= w_seqSet | (r_seqErr & ~clr_err);
      r_patErr <= w_patSet | (r_patErr & ~clr_err);
    end
  end

  assign digit_out   = r_digit;
  assign digit_valid = r_valid;
  assign seq_err     = r_seqErr;
  assign pat_err     = r_patErr;
  assign period_out  = r_period;
  assign tracking    = (r_state == TRACK);

endmodule

// File: tb/tb_seven_segment_monitor.sv
// tb_seven_segment_monitor
//
// Purpose:
//   Self-checking bench for seven_segment_monitor (PERIOD_W=8 so that
//   saturation is reachable). A behavioural model keeps the sampled history
//   as a run length of identical samples and timestamps of accepted digits.
//   It is compared every cycle with the DUT. Each scenario task also makes
//   directed checks against known values.
//
// Configuration:
//   SEVEN_SEGMENT_MONITOR_HEX_EN - must match the build of the DUT.
module tb_seven_segment_monitor;

  localparam int STABLE = 4;
  localparam int PW     = 8;
  localparam int MAXP   = (1 << PW) - 1;
`ifdef SEVEN_SEGMENT_MONITOR_HEX_EN
  localparam int MOD    = 16;
`else
  localparam int MOD    = 10;
`endif
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_in = 7'h00;
  logic          clr_err = 1'b0;
  logic [3:0]    digit_out;
  logic          digit_valid;
  logic          seq_err;
  logic          pat_err;
  logic [PW-1:0] period_out;
  logic          tracking;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seven_segment_monitor #(.STABLE_CYCLES(STABLE), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clr_err(clr_err),
    .digit_out(digit_out), .digit_valid(digit_valid), .seq_err(seq_err),
    .pat_err(pat_err), .period_out(period_out), .tracking(tracking));

  // Behavioural model state.
  logic [6:0]    mD1, mD2, mRunVal, mSeen;
  int            mRunLen, mDec;
  logic [3:0]    mDigit;
  logic          mValid, mSeq, mPat, mTrack, mSeqSet, mPatSet;
  logic [PW-1:0] mPeriod;
  longint        mEdge, mLastEdge;

  // Returns the digit, -2 for blank, -1 for any other pattern.
  function automatic int decodeGlyph(input logic [6:0] p);
    if (p == 7'h00) return -2;
    for (int i = 0; i < MOD; i++) if (GLYPHS[i] == p) return i;
    return -1;
  endfunction

  // A pattern is evaluated on the edge at which it has been the sampled
  // value (two edges of sync delay) for STABLE+1 consecutive edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mD1 = '0; mD2 = '0; mRunVal = '0; mRunLen = 1;
      mDigit = '0; mValid = 0; mSeq = 0; mPat = 0; mTrack = 0;
      mPeriod = '0; mEdge = 0; mLastEdge = 0;
    end else begin
      mEdge++;
      mSeen = mD2; mD2 = mD1; mD1 = seg_in;
      if (mSeen == mRunVal) begin
        if (mRunLen < STABLE + 2) mRunLen++;
      end else begin
        mRunVal = mSeen; mRunLen = 1;
      end
      mValid = 0; mSeqSet = 0; mPatSet = 0;
      if (mRunLen == STABLE + 1) begin
        mDec = decodeGlyph(mSeen);
        if (mDec >= 0) begin
          if (mTrack) begin
            if (mDec != (int'(mDigit) + 1) % MOD) mSeqSet = 1;
            mPeriod = PW'((mEdge - mLastEdge > MAXP) ? MAXP : (mEdge - mLastEdge));
          end
          mLastEdge = mEdge;
          mDigit = 4'(mDec);
          mValid = 1;
          mTrack = 1;
        end else begin
          if (mDec == -1) mPatSet = 1;
          mTrack = 0;
        end
      end
      mSeq = mSeqSet | (mSeq & ~clr_err);
      mPat = mPatSet | (mPat & ~clr_err);
    end
  end

  logic [15:0] dutBus, expBus;
  assign dutBus = {digit_out, digit_valid, seq_err, pat_err, period_out, tracking};
  assign expBus = {mDigit, mValid, mSeq, mPat, mPeriod, mTrack};

  // Per-cycle record of divergence from the model; tasks inspect it.
  int          diffCount = 0;
  time         firstDiffT = 0;
  logic [15:0] firstDut = '0, firstExp = '0;
  int          pulseCount = 0;

  always @(negedge clk) begin
    if (digit_valid) pulseCount++;
    if (dutBus !== expBus) begin
      if (diffCount == 0) begin
        firstDiffT = $time; firstDut = dutBus; firstExp = expBus;
      end
      diffCount++;
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; seg_in = 7'h00; clr_err = 1'b0;
    #22;
    checks++;
    if (dutBus !== 16'h0) $display("[TB] FAIL reset_outputs got %h want 0000", dutBus);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_glyph;
    int d0, np, pe;
    d0 = diffCount; np = 0; pe = 0;
    seg_in = 7'h3F;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (digit_valid) begin np++; pe = e; end
    end
    @(negedge clk);
    checks++;
    if (np !== 1 || pe !== STABLE + 3)
      $display("[TB] FAIL first_pulse got count=%0d edge=%0d want count=1 edge=%0d", np, pe, STABLE + 3);
    else passes++;
    checks++;
    if ({digit_out, tracking, seq_err, period_out} !== {4'd0, 1'b1, 1'b0, 8'd0})
      $display("[TB] FAIL first_state got d=%0d t=%b s=%b p=%0d want d=0 t=1 s=0 p=0",
               digit_out, tracking, seq_err, period_out);
    else passes++;
    checks++;
    if (diffCount !== d0) $display("[TB] FAIL first_model got %0d diffs want 0", diffCount - d0);
    else passes++;
  endtask

  task automatic test_sequence;
    int d0, p0;
    d0 = diffCount; p0 = pulseCount;
    hold(7'h06, 100);
    hold(7'h5B, 100);
    checks++;
    if (period_out !== 8'd100) $display("[TB] FAIL period_2nd got %0d want 100", period_out);
    else passes++;
    hold(7'h4F, 100);
    checks++;
    if (pulseCount - p0 !== 3 || digit_out !== 4'd3 || period_out !== 8'd100 || seq_err !== 1'b0)
      $display("[TB] FAIL seq_run got pulses=%0d d=%0d p=%0d s=%b want 3 3 100 0",
               pulseCount - p0, digit_out, period_out, seq_err);
    else passes++;
    checks++;
    if (diffCount !== d0) $display("[TB] FAIL seq_model got %0d diffs want 0", diffCount - d0);
    else passes++;
  endtask

  task automatic test_wrap_and_clear;
    int d0;
    d0 = diffCount;
    hold(7'h00, 20);
    hold(7'h6F, 20);
    hold(7'h3F, 20);
    checks++;
    if (digit_out !== 4'd0 || seq_err !== 1'b0)
      $display("[TB] FAIL wrap got d=%0d s=%b want d=0 s=0", digit_out, seq_err);
    else passes++;
    hold(7'h6D, 20);
    checks++;
    if (seq_err !== 1'b1) $display("[TB] FAIL seq_skip got %b want 1", seq_err);
    else passes++;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (seq_err !== 1'b0 || digit_out !== 4'd5)
      $display("[TB] FAIL clr_err got s=%b d=%0d want s=0 d=5", seq_err, digit_out);
    else passes++;
    // Clear asserted exactly on the evaluation edge of a bad digit.
    seg_in = 7'h3F;
    repeat (STABLE + 2) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (seq_err !== 1'b1 || digit_valid !== 1'b1)
      $display("[TB] FAIL set_wins got s=%b v=%b want s=1 v=1", seq_err, digit_valid);
    else passes++;
    hold(7'h3F, 10);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (diffCount !== d0) $display("[TB] FAIL wrap_model got %0d diffs want 0", diffCount - d0);
    else passes++;
  endtask

  task automatic test_glitch;
    int d0, bad;
    d0 = diffCount; bad = 0;
    hold(7'h06, 20);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 10; c++) begin
        seg_in = (c < 2) ? 7'h7F : 7'h06;
        @(negedge clk);
        if (digit_valid && digit_out == 4'd8) bad++;
      end
    end
    checks++;
    if (bad !== 0 || digit_out !== 4'd1 || seq_err !== 1'b1)
      $display("[TB] FAIL glitch got bad=%0d d=%0d s=%b want 0 1 1", bad, digit_out, seq_err);
    else passes++;
    hold(7'h7F, 20);
    checks++;
    if (digit_out !== 4'd8) $display("[TB] FAIL glitch_accept got %0d want 8", digit_out);
    else passes++;
    checks++;
    if (diffCount !== d0) $display("[TB] FAIL glitch_model got %0d diffs want 0", diffCount - d0);
    else passes++;
  endtask

  task automatic test_illegal;
    int d0, p0;
    logic [PW-1:0] per;
    logic s;
    d0 = diffCount;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    hold(7'h01, 20);
    checks++;
    if (pat_err !== 1'b1 || tracking !== 1'b0 || digit_out !== 4'd8)
      $display("[TB] FAIL illegal got pe=%b t=%b d=%0d want 1 0 8", pat_err, tracking, digit_out);
    else passes++;
    p0 = pulseCount;
    hold(7'h00, 20);
    checks++;
    if (pulseCount !== p0 || pat_err !== 1'b1)
      $display("[TB] FAIL blank got pulses=%0d pe=%b want 0 1", pulseCount - p0, pat_err);
    else passes++;
    per = period_out; s = seq_err;
    hold(7'h3F, 20);
    checks++;
    if (digit_out !== 4'd0 || tracking !== 1'b1 || period_out !== per || seq_err !== s)
      $display("[TB] FAIL after_idle got d=%0d t=%b p=%0d s=%b want 0 1 %0d %b",
               digit_out, tracking, period_out, seq_err, per, s);
    else passes++;
    checks++;
    if (diffCount !== d0) $display("[TB] FAIL illegal_model got %0d diffs want 0", diffCount - d0);
    else passes++;
  endtask

  task automatic test_saturation_and_reset;
    int d0;
    d0 = diffCount;
    hold(7'h07, 300);
    hold(7'h7F, 10);
    checks++;
    if (period_out !== 8'hFF || digit_out !== 4'd8)
      $display("[TB] FAIL saturate got p=%0d d=%0d want 255 8", period_out, digit_out);
    else passes++;
    hold(7'h7F, 3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dutBus !== 16'h0) $display("[TB] FAIL async_reset got %h want 0000", dutBus);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    hold(7'h3F, 20);
    checks++;
    if (digit_out !== 4'd0 || seq_err !== 1'b0 || period_out !== 8'd0 || tracking !== 1'b1)
      $display("[TB] FAIL post_reset got d=%0d s=%b p=%0d t=%b want 0 0 0 1",
               digit_out, seq_err, period_out, tracking);
    else passes++;
    checks++;
    if (diffCount !== d0) $display("[TB] FAIL sat_model got %0d diffs want 0", diffCount - d0);
    else passes++;
  endtask

  task automatic test_random;
    int d0, sel;
    logic [6:0] p;
    d0 = diffCount;
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      p = GLYPHS[(int'(mDigit) + 1) % MOD];
      else if (sel < 7) p = GLYPHS[$urandom_range(0, 15)];
      else if (sel < 8) p = 7'h00;
      else              p = 7'($urandom_range(0, 127));
      clr_err = ($urandom_range(0, 7) == 0);
      hold(p, $urandom_range(1, 12));
    end
    clr_err = 1'b0;
    hold(7'h00, 10);
    checks++;
    if (diffCount !== d0)
      $display("[TB] FAIL random_model got %0d diffs (first t=%0t dut=%h exp=%h) want 0",
               diffCount - d0, firstDiffT, firstDut, firstExp);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_first_glyph();
    test_sequence();
    test_wrap_and_clear();
    test_glitch();
    test_illegal();
    test_saturation_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_monitor.md
Name: seven_segment_monitor

Overview:
Reader for our seven-segment digit output. It samples a 7-bit segment bus, such as another tile's display pins looped back through `ui_in`, and filters out glitches. It decodes each stable pattern back to a BCD digit, checks that digits advance 0→9→0 in order, and measures the clock-cycle period between successive digit updates. This lets a counter design on the same die self-check its display path.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples needed to accept a pattern (≥2).
- PERIOD_W, 24, width of the period counter and `period_out`.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- seg_in  input  7  segment bus {g,f,e,d,c,b,a}, active high, asynchronous to clk
- clr_err  input  1  synchronous clear of the sticky error flags
- digit_out  output  4  last accepted digit
- digit_valid  output  1  one-cycle pulse when `digit_out` updates
- seq_err  output  1  sticky: accepted digit ≠ previous digit + 1 (mod 10)
- pat_err  output  1  sticky: stable pattern is not a legal glyph and not blank
- period_out  output  PERIOD_W  cycles between the last two `digit_valid` pulses
- tracking  output  1  high while in the TRACK state

Behaviour:
- Reset (async, rst_n=0): all outputs 0; synchronizer, candidate and counters 0; state IDLE.
- Synchronizer: 2-flop chain on `seg_in` gives s2.
- Stability filter:
  - If s2 ≠ cand: cand←s2, stab_cnt←0, reported←0.
  - Else if stab_cnt < STABLE_CYCLES−1: stab_cnt++.
  - Else if reported=0: evaluate cand, then reported←1.
  - Each stable pattern is evaluated exactly once.
- Latency: a pattern held from before edge 1 is evaluated and `digit_valid` is high after edge STABLE_CYCLES+3 (edge 7 for the default).
- Legal glyphs (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Evaluation of a legal glyph d:
  - digit_out←d; digit_valid pulses 1 cycle.
  - If in TRACK and d ≠ (digit_out_prev+1) mod 10: seq_err←1.
  - If in TRACK: period_out←period_cnt.
  - period_cnt←0; state→TRACK.
- Evaluation of blank (00): state→IDLE; no pulse; no error; `digit_out` holds.
- Evaluation of any other pattern: pat_err←1; state→IDLE; `digit_out` holds; no pulse.
- period_cnt: increments every cycle, saturating at all-ones. Saturation is not an error.
- State machine:
  - IDLE → TRACK on the first legal glyph.
  - TRACK → IDLE on blank or an illegal pattern.
  - The first glyph after IDLE never sets `seq_err` and does not update `period_out`.
- Repeated identical glyph (bus re-glitches, then returns to the same value): re-evaluated. Same digit counts as a sequence error, since d ≠ prev+1.
- clr_err=1 clears `seq_err` and `pat_err` next edge.
  - If an error event occurs in the same cycle, the set wins.
  - clr_err does not affect state, `period_out` or `digit_out`.
- Reset mid-operation: immediate return to reset values. The first glyph after release behaves as after IDLE.

Optional Feature:
- Macro: SEVEN_SEGMENT_MONITOR_HEX_EN.
- Defined:
  - Glyphs A=77, b=7C, C=39, d=5E, E=79, F=71 are also legal, decoding to 10–15.
  - Sequence check becomes d ≠ (prev+1) mod 16.
- Undefined: these patterns set `pat_err`, and the sequence wraps mod 10.

Test Plan:
1. Reset, then hold seg_in=3F for 20 cycles → digit_valid pulses once, at edge 7 after the pattern appears; digit_out=0; tracking=1; seq_err=0; period_out=0.
2. Drive 06, 5B, 4F, each held exactly 100 cycles → three pulses; digit_out ends at 3; period_out=100 after the 2nd and 3rd pulses; seq_err=0.
3. Drive 6F (9) then 3F (0) → wrap accepted, seq_err=0. Then drive 6D (5) → seq_err=1. Assert clr_err for 1 cycle → seq_err=0.
4. During a stable 06, inject 2-cycle glitches to 7F every 10 cycles (STABLE_CYCLES=4) → no digit_valid for the glitch value. Hold 06 and the glitch value 7F each long enough to pass the filter: each becomes an accepted digit.
5. Drive stable 01 → pat_err=1, tracking=0, digit_out unchanged. Drive 00 afterwards → no pulse. Then drive 3F → accepted, seq_err unchanged, period_out unchanged.
6. Hold 07 for more than 2^PERIOD_W cycles (use PERIOD_W=8), then drive 7F → period_out=FF (saturated). Pull rst_n low mid-count → all outputs 0 asynchronously.
